// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit CLA group per stage, global-enable flow control.
// Define CLA_SAT_EN to saturate out_sum on signed overflow instead of wrapping.
module cla_pipe_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned N = WIDTH / BLOCK;

   logic             advance;
   logic             fin_valid;
   logic [WIDTH-1:0] fin_sum;
   logic             fin_cout;
   logic             fin_ovf;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Two-level carry equations: each carry is an OR of generate/propagate products, no chain.
   function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] p,
                                                input logic [BLOCK-1:0] g,
                                                input logic             c0);
      logic [BLOCK:0] cy;
      logic           term;
      cy    = '0;
      cy[0] = c0;
      for (int unsigned i = 0; i < BLOCK; i++) begin
         term = c0;
         for (int unsigned j = 0; j <= i; j++) term = term & p[j];
         cy[i+1] = term;
         for (int unsigned j = 0; j <= i; j++) begin
            term = g[j];
            for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
            cy[i+1] = cy[i+1] | term;
         end
      end
      return cy;
   endfunction

   for (genvar k = 0; k < N; k++) begin : stg
      localparam int unsigned LO = k * BLOCK;
      localparam int unsigned RW = WIDTH - LO;

      logic [RW-1:0]       a_i;
      logic [RW-1:0]       b_i;
      logic                c_i;
      logic                v_i;
      logic [BLOCK-1:0]    p;
      logic [BLOCK-1:0]    g;
      logic [BLOCK:0]      cy;
      logic [BLOCK-1:0]    grp_sum;
      logic [LO+BLOCK-1:0] s_cur;

      if (k == 0) begin : src
         assign a_i   = in_a;
         assign b_i   = in_sub ? ~in_b : in_b;
         assign c_i   = in_cin ^ in_sub;
         assign v_i   = in_valid;
         assign s_cur = grp_sum;
      end else begin : src
         assign a_i   = stg[k-1].fwd.a_o;
         assign b_i   = stg[k-1].fwd.b_o;
         assign c_i   = stg[k-1].fwd.c_o;
         assign v_i   = stg[k-1].fwd.v_o;
         assign s_cur = {grp_sum, stg[k-1].fwd.s_o};
      end

      assign p       = a_i[BLOCK-1:0] ^ b_i[BLOCK-1:0];
      assign g       = a_i[BLOCK-1:0] & b_i[BLOCK-1:0];
      assign cy      = lookahead(p, g, c_i);
      assign grp_sum = p ^ cy[BLOCK-1:0];

      if (k < N - 1) begin : fwd
         // Only the not-yet-consumed operand bits travel on; finished sum bits ride along below.
         logic [RW-BLOCK-1:0] a_o;
         logic [RW-BLOCK-1:0] b_o;
         logic [LO+BLOCK-1:0] s_o;
         logic                c_o;
         logic                v_o;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_o <= '0;
               b_o <= '0;
               s_o <= '0;
               c_o <= 1'b0;
               v_o <= 1'b0;
            end else if (advance) begin
               a_o <= a_i[RW-1:BLOCK];
               b_o <= b_i[RW-1:BLOCK];
               s_o <= s_cur;
               c_o <= cy[BLOCK];
               v_o <= v_i;
            end
         end
      end else begin : fin
         assign fin_valid = v_i;
         assign fin_cout  = cy[BLOCK];
         assign fin_ovf   = cy[BLOCK] ^ cy[BLOCK-1];
`ifdef CLA_SAT_EN
         logic [WIDTH-1:0] sat;
         // Overflow implies both effective operands share the sign of a's MSB.
         always_comb begin
            sat          = {WIDTH{~a_i[BLOCK-1]}};
            sat[WIDTH-1] = a_i[BLOCK-1];
            fin_sum      = fin_ovf ? sat : s_cur;
         end
`else
         assign fin_sum = s_cur;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (advance) begin
         out_valid <= fin_valid;
         out_sum   <= fin_sum;
         out_cout  <= fin_cout;
         out_ovf   <= fin_ovf;
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomized and directed bench for cla_pipe_adder against an arithmetic reference model and scoreboard.
// Honours CLA_SAT_EN the same way the design does.
module tb_cla_pipe_adder;

   localparam int unsigned W = 16;
   localparam int unsigned B = 4;
   localparam int unsigned N = W / B;

`ifdef CLA_SAT_EN
   localparam logic [W-1:0] S_OVF_ADD = 16'h7FFF;
   localparam logic [W-1:0] S_OVF_SUB = 16'h8000;
`else
   localparam logic [W-1:0] S_OVF_ADD = 16'h8000;
   localparam logic [W-1:0] S_OVF_SUB = 16'h7FFF;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   int checks = 0;
   int errors = 0;
   int got_n  = 0;

   logic [W+1:0] q[$];
   logic [W+1:0] e;

   cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {ovf, cout, sum} from plain wide arithmetic.
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
      logic [W-1:0] be;
      logic [W:0]   full;
      logic [W-1:0] s;
      logic         ovf;
      be   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin ^ sub};
      s    = full[W-1:0];
      ovf  = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
`ifdef CLA_SAT_EN
      if (ovf) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      return {ovf, full[W], s};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b0, {(W-1){1'b1}}};
         3: return {1'b1, {(W-1){1'b0}}};
         default: return W'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(out_sum), 64'hDEAD_0000);
            end else begin
               e = q.pop_front();
               check("sb_sum", 64'(out_sum), 64'(e[W-1:0]));
               check("sb_cout", 64'(out_cout), 64'(e[W]));
               check("sb_ovf", 64'(out_ovf), 64'(e[W+1]));
               got_n++;
            end
         end
         if (in_valid && in_ready) q.push_back(ref_add(in_a, in_b, in_cin, in_sub));
      end
   end

   // Entered and left at posedge+1 with out_ready high and the pipe idle.
   task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input logic [W-1:0] xs, input logic xc,
                           input logic xo, input string tag);
      int cyc;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, 64'(cyc), 64'(N));
      check({tag, "_sum"}, 64'(out_sum), 64'(xs));
      check({tag, "_cout"}, 64'(out_cout), 64'(xc));
      check({tag, "_ovf"}, 64'(out_ovf), 64'(xo));
   endtask

   logic [W+2:0] hold;
   logic         took;
   int           si;
   int           g0;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 64'(out_valid), 0);
      check("rst_sum", 64'(out_sum), 0);
      check("rst_cout", 64'(out_cout), 0);
      check("rst_ovf", 64'(out_ovf), 0);
      check("rst_ready", 64'(in_ready), 1);
      @(posedge clk); #1;

      send_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add");
      send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "chain");
      send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, S_OVF_ADD, 1'b0, 1'b1, "ovf_add");
      send_one(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "borrow");
      send_one(16'h8000, 16'h0001, 1'b0, 1'b1, S_OVF_SUB, 1'b1, 1'b1, "ovf_sub");
      repeat (2) @(posedge clk); #1;

      // Streaming with a three-cycle output stall.
      g0 = got_n;
      fork
         begin
            si = 0;
            while (si < 8) begin
               in_a = W'(si); in_b = W'(si * 256); in_cin = 1'b0; in_sub = 1'b0;
               in_valid = 1'b1;
               @(negedge clk); took = in_ready;
               @(posedge clk); #1;
               if (took) si++;
            end
            in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b0;
            check("stall_valid", 64'(out_valid), 1);
            hold = {out_valid, out_cout, out_ovf, out_sum};
            repeat (3) begin
               @(negedge clk);
               check("stall_rdy", 64'(in_ready), 0);
               check("stall_hold", 64'({out_valid, out_cout, out_ovf, out_sum}), 64'(hold));
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      repeat (20) @(posedge clk); #1;
      check("stream_count", 64'(got_n - g0), 8);
      check("stream_empty", 64'(q.size()), 0);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         in_a = W'(i + 1); in_b = W'(100); in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      q.delete();
      @(posedge clk); #1 rst = 1'b0;
      check("mid_rst_valid", 64'(out_valid), 0);
      check("mid_rst_sum", 64'(out_sum), 0);
      check("mid_rst_ready", 64'(in_ready), 1);
      repeat (6) begin
         @(negedge clk);
         check("mid_rst_quiet", 64'(out_valid), 0);
      end
      @(posedge clk); #1;
      send_one(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h0FFF + 16'h0001, 1'b0, 1'b0, "post_rst");

      // Randomized traffic with random backpressure.
      took = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = pick(); in_b = pick();
            in_cin = 1'($urandom); in_sub = 1'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk); took = in_valid && in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 100 && q.size() != 0; c++) @(posedge clk);
      #1;
      check("drain_empty", 64'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout got=%0d checks", checks);
      $fatal(1);
   end

endmodule
